instr_fetch_queue: RTL and testbench

//  Fetch stage directly downstream of the PC stage. Takes the current PC and issues

---
 rtl/instr_fetch_queue.sv | 177 +++++++++++++++++
 tb/tb_instr_fetch_queue.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// ============================================================================
//  Module      : instr_fetch_queue
//  Description : Fetch stage. Issues word reads over req/ack and buffers
//                {PC, instruction} pairs in a DEPTH-entry FIFO for decode.
//                Define FETCH_PERF_CNT_EN to add the fetch/stall counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] PC,
    input  logic             flush,
    output logic             PC_stall,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]      perf_fetch_cnt,
    output logic [31:0]      perf_stall_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [CW-1:0]    count_q;
    logic [AW-1:0]    rptr_q, wptr_q;
    logic [WIDTH-1:0] mem_instr_q [DEPTH];
    logic [WIDTH-1:0] mem_pc_q    [DEPTH];

    logic [WIDTH-1:0] w_pc_aligned;
    logic             w_space;
    logic             w_ack_live;
    logic             w_push;
    logic             w_pop;
    logic             w_pc_lo_unused;

    assign w_pc_aligned   = {PC[WIDTH-1:2], 2'b00};
    assign w_pc_lo_unused = ^PC[1:0];
    assign w_space        = (count_q < C_DEPTH);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        imem_req  = 1'b0;
        imem_addr = addr_q;
        case (state_q)
            S_IDLE: begin
                imem_addr = w_pc_aligned;
                if (!flush && w_space) begin
                    imem_req = 1'b1;
                    if (!imem_ack) begin
                        state_d = S_WAIT;
                        addr_d  = w_pc_aligned;
                    end
                end
            end
            S_WAIT: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_d = S_IDLE;
                end else if (flush) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Outputs are defined as quiet while reset is held, not just after it.
        if (rst) begin
            imem_req  = 1'b0;
            imem_addr = '0;
        end
    end

    assign w_ack_live  = imem_req && imem_ack && (state_q != S_DROP);
    assign w_push      = w_ack_live && !flush;
    assign instr_valid = (count_q != '0);
    assign w_pop       = instr_valid && instr_ready && !flush;
    assign PC_stall    = !w_ack_live && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            rptr_q  <= '0;
            wptr_q  <= '0;
        end else if (flush) begin
            count_q <= '0;
            rptr_q  <= '0;
            wptr_q  <= '0;
        end else begin
            if (w_push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (w_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            if (w_push && !w_pop) begin
                count_q <= count_q + CW'(1);
            end else if (w_pop && !w_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Storage needs no reset: a slot is only read after being written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_instr_q[wptr_q] <= imem_rdata;
            mem_pc_q[wptr_q]    <= addr_q;
            if (state_q == S_IDLE) begin
                mem_pc_q[wptr_q] <= w_pc_aligned;
            end
        end
    end

    assign instr    = instr_valid ? mem_instr_q[rptr_q] : '0;
    assign instr_pc = instr_valid ? mem_pc_q[rptr_q]    : '0;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (w_push) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (count_q == C_DEPTH) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
// ============================================================================
//  Module      : tb_instr_fetch_queue
//  Description : Randomized self-checking bench for instr_fetch_queue against
//                a queue-based reference model with a variable-latency memory.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_queue;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] PC;
    logic             flush;
    logic             PC_stall;
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ack;
    logic [WIDTH-1:0] imem_rdata;
    logic             instr_valid;
    logic             instr_ready;
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] instr_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]      perf_fetch_cnt;
    logic [31:0]      perf_stall_cnt;
`endif

    instr_fetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .PC          (PC),
        .flush       (flush),
        .PC_stall    (PC_stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } entry_t;

    // Reference model: decode-side queue, one-outstanding-request tracker,
    // the PC register, and a memory that answers after 0..3 cycles.
    entry_t      q[$];
    bit          m_pend;
    bit          m_drop;
    logic [31:0] m_addr;
    logic [31:0] pc;
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] m_fetch;
    logic [31:0] m_stall;

    function automatic logic [31:0] align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    task automatic step(input int ready_pct, input int flush_pct);
        bit          exp_req, ack, acc, exp_stall;
        int          new_lat;
        logic [31:0] exp_addr, target;
        @(negedge clk);
        flush       = ($urandom_range(0, 99) < flush_pct);
        instr_ready = ($urandom_range(0, 99) < ready_pct);
        imem_rdata  = $urandom;
        PC          = pc;
        target      = $urandom;
        exp_req  = (m_pend && !m_drop) ||
                   (!m_pend && !m_drop && !flush && (q.size() < DEPTH));
        exp_addr = m_pend ? m_addr : align(pc);
        new_lat  = $urandom_range(0, 3);
        ack      = mem_busy ? (mem_cnt == 0) : (exp_req && new_lat == 0);
        imem_ack = ack;
        acc       = exp_req && ack && !m_drop && !flush;
        exp_stall = !(exp_req && ack && !m_drop) && !flush;
        #1;
        check_eq("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        if (exp_req) check_eq("imem_addr", imem_addr, exp_addr);
        check_eq("PC_stall", {31'd0, PC_stall}, {31'd0, exp_stall});
        check_eq("instr_valid", {31'd0, instr_valid}, {31'd0, q.size() != 0});
        if (q.size() != 0) begin
            check_eq("instr", instr, q[0].ins);
            check_eq("instr_pc", instr_pc, q[0].pc);
        end
`ifdef FETCH_PERF_CNT_EN
        check_eq("perf_fetch_cnt", perf_fetch_cnt, m_fetch);
        check_eq("perf_stall_cnt", perf_stall_cnt, m_stall);
`endif
        @(posedge clk);
        if (acc) m_fetch = m_fetch + 32'd1;
        if (q.size() == DEPTH) m_stall = m_stall + 32'd1;
        if (flush) begin
            q.delete();
        end else begin
            if (q.size() != 0 && instr_ready) void'(q.pop_front());
            if (acc) q.push_back('{pc: exp_addr, ins: imem_rdata});
        end
        if (m_drop) begin
            if (ack) m_drop = 0;
        end else if (m_pend) begin
            if (ack) m_pend = 0;
            else if (flush) begin
                m_pend = 0;
                m_drop = 1;
            end
        end else if (exp_req && !ack) begin
            m_pend = 1;
            m_addr = align(pc);
        end
        if (ack) mem_busy = 0;
        else if (mem_busy) mem_cnt--;
        else if (exp_req) begin
            mem_busy = 1;
            mem_cnt  = new_lat - 1;
        end
        if (flush) pc = target;
        else if (!exp_stall) pc = pc + 32'd4;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst         = 1'b1;
        flush       = 1'b0;
        imem_ack    = 1'b0;
        instr_ready = 1'b0;
        #1;
        check_eq("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check_eq("rst_imem_addr", imem_addr, 32'd0);
        check_eq("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("rst_PC_stall", {31'd0, PC_stall}, 32'd1);
        check_eq("rst_instr", instr, 32'd0);
        check_eq("rst_instr_pc", instr_pc, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check_eq("rst_perf_fetch", perf_fetch_cnt, 32'd0);
        check_eq("rst_perf_stall", perf_stall_cnt, 32'd0);
`endif
        q.delete();
        m_pend   = 0;
        m_drop   = 0;
        mem_busy = 0;
        mem_cnt  = 0;
        m_fetch  = '0;
        m_stall  = '0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        int guard;
        rst         = 1'b1;
        flush       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b0;
        pc          = 32'h0000_0100;
        PC          = pc;
        m_addr      = '0;
        apply_reset();

        repeat (150) step(90, 0);
        repeat (150) step(0, 0);
        repeat (200) step(30, 5);
        repeat (200) step(100, 8);

        // Reset while a request is outstanding.
        guard = 0;
        while (!(m_pend && !m_drop) && guard < 200) begin
            step(50, 0);
            guard++;
        end
        check_eq("reach_wait", {31'd0, m_pend}, 32'd1);
        apply_reset();

        repeat (300) step(50, 10);
        repeat (150) step(10, 3);
        repeat (200) step(80, 15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
